// File: rtl/matmul_pkg.sv
// -----------------------------------------------------------------------------
// matmul_pkg
// Shared declarations for the sequential matrix-multiply core:
//   - state_e          : controller FSM states
//   - MODE_*           : bit positions inside the latched mode word
//   - OP_SEL_*         : operand select encoding (A or B)
//   - clog2()          : elaboration-time ceiling log2 for index widths
// -----------------------------------------------------------------------------
package matmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MAC  = 2'd1,
      ST_WB   = 2'd2,
      ST_DONE = 2'd3
   } state_e;

   localparam int MODE_SIGNED_BIT = 0;
   localparam int MODE_ACC_BIT    = 1;
   localparam int MODE_WIDTH      = 2;

   localparam logic OP_SEL_A = 1'b0;
   localparam logic OP_SEL_B = 1'b1;

   function automatic int clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/matmul_seq_core_if.sv
// -----------------------------------------------------------------------------
// matmul_seq_core_if
// Load / start / read port bundle between the register-file layer (master)
// and matmul_seq_core (slave).
//   start_i, dim_*_i, signed_i, acc_i : job request and its parameters
//   op_we_i, op_sel_i, op_row/col_i, op_data_i : operand element write
//   res_row/col_i -> res_data_o, res_ovf_o      : registered result read
//   busy_o, done_o, err_o                       : status
// -----------------------------------------------------------------------------
interface matmul_seq_core_if #(
   parameter int DATA_WIDTH = 8,
   parameter int IDX_WIDTH  = 2,
   parameter int RES_WIDTH  = 32
);

   logic                  start_i;
   logic [IDX_WIDTH-1:0]  dim_n_i;
   logic [IDX_WIDTH-1:0]  dim_k_i;
   logic [IDX_WIDTH-1:0]  dim_m_i;
   logic                  signed_i;
   logic                  acc_i;
   logic                  op_we_i;
   logic                  op_sel_i;
   logic [IDX_WIDTH-1:0]  op_row_i;
   logic [IDX_WIDTH-1:0]  op_col_i;
   logic [DATA_WIDTH-1:0] op_data_i;
   logic [IDX_WIDTH-1:0]  res_row_i;
   logic [IDX_WIDTH-1:0]  res_col_i;
   logic [RES_WIDTH-1:0]  res_data_o;
   logic                  res_ovf_o;
   logic                  busy_o;
   logic                  done_o;
   logic                  err_o;

   modport master (
      output start_i, dim_n_i, dim_k_i, dim_m_i, signed_i, acc_i,
             op_we_i, op_sel_i, op_row_i, op_col_i, op_data_i,
             res_row_i, res_col_i,
      input  res_data_o, res_ovf_o, busy_o, done_o, err_o
   );

   modport slave (
      input  start_i, dim_n_i, dim_k_i, dim_m_i, signed_i, acc_i,
             op_we_i, op_sel_i, op_row_i, op_col_i, op_data_i,
             res_row_i, res_col_i,
      output res_data_o, res_ovf_o, busy_o, done_o, err_o
   );

endinterface

// File: rtl/matmul_mac.sv
// -----------------------------------------------------------------------------
// matmul_mac
// Combinational multiply-accumulate step: sum_o = acc_i + a_i * b_i.
//   signed_i : 1 = operands, accumulator and result are two's complement
//   a_i, b_i : operand elements (DATA_WIDTH)
//   acc_i    : running accumulator (RES_WIDTH), ovf_i its sticky flag
//   sum_o    : new accumulator, wrapped modulo 2^RES_WIDTH
//   ovf_o    : ovf_i OR this step left the RES_WIDTH signed/unsigned range
// -----------------------------------------------------------------------------
module matmul_mac
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int RES_WIDTH  = 32
) (
   input  logic                  signed_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [RES_WIDTH-1:0]  acc_i,
   input  logic                  ovf_i,
   output logic [RES_WIDTH-1:0]  sum_o,
   output logic                  ovf_o
);

   localparam int PROD_WIDTH = 2 * DATA_WIDTH;
   localparam int EXT_WIDTH  = RES_WIDTH + 1;

   logic [PROD_WIDTH-1:0] prod_s;
   logic [PROD_WIDTH-1:0] prod_u;
   logic [PROD_WIDTH-1:0] prod;
   logic [EXT_WIDTH-1:0]  prod_ext;
   logic [EXT_WIDTH-1:0]  acc_ext;
   logic [EXT_WIDTH-1:0]  sum_ext;
   logic                  range_err;

   // NOTE: every signal in this block is assigned on every path, so no
   // latch can be inferred; keep it that way when adding modes.
   always_comb begin
      // The low 2*DATA_WIDTH bits of a product of pre-extended operands are
      // exact for both signed and unsigned interpretations.
      prod_s = {{DATA_WIDTH{a_i[DATA_WIDTH-1]}}, a_i} *
               {{DATA_WIDTH{b_i[DATA_WIDTH-1]}}, b_i};
      prod_u = {{DATA_WIDTH{1'b0}}, a_i} * {{DATA_WIDTH{1'b0}}, b_i};
      prod   = signed_i ? prod_s : prod_u;

      prod_ext = signed_i ? {{(EXT_WIDTH-PROD_WIDTH){prod[PROD_WIDTH-1]}}, prod}
                          : {{(EXT_WIDTH-PROD_WIDTH){1'b0}}, prod};
      acc_ext  = signed_i ? {acc_i[RES_WIDTH-1], acc_i} : {1'b0, acc_i};
      sum_ext  = acc_ext + prod_ext;

      // One guard bit holds the exact sum: signed overflow shows as the two
      // top bits disagreeing, unsigned overflow as a carry into the guard.
      range_err = signed_i ? (sum_ext[RES_WIDTH] ^ sum_ext[RES_WIDTH-1])
                           : sum_ext[RES_WIDTH];

      sum_o = sum_ext[RES_WIDTH-1:0];
      ovf_o = ovf_i | range_err;
   end

endmodule

// File: rtl/matmul_seq_core.sv
// -----------------------------------------------------------------------------
// matmul_seq_core
// Sequential C = A*B or C = C + A*B with run-time dimensions up to MAX_DIM,
// one MAC per cycle, per-element sticky overflow flags.
//   clk_i, rst_i : clock (rising edge), asynchronous active-high reset
//   bus (slave)  : operand writes, job start, result reads, status
// Each result element takes K MAC cycles plus one write-back cycle, so a job
// keeps busy_o high for N*M*(K+1) cycles, followed by a one-cycle done_o.
// -----------------------------------------------------------------------------
module matmul_seq_core
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAX_DIM    = 4,
   parameter int RES_WIDTH  = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   matmul_seq_core_if.slave  bus
);

   localparam int IDX_WIDTH = clog2(MAX_DIM);

   typedef logic [IDX_WIDTH-1:0] idx_t;

   state_e                 state_q;
   idx_t                   n_q, k_q, m_q;
   idx_t                   i_q, j_q, kk_q;
   logic [MODE_WIDTH-1:0]  mode_q;
   logic [RES_WIDTH-1:0]   acc_q;
   logic                   ovf_q;
   logic                   busy_q, done_q, err_q;
   logic [RES_WIDTH-1:0]   res_data_q;
   logic                   res_ovf_q;

   logic [DATA_WIDTH-1:0]  a_mem    [MAX_DIM][MAX_DIM];
   logic [DATA_WIDTH-1:0]  b_mem    [MAX_DIM][MAX_DIM];
   logic [RES_WIDTH-1:0]   c_mem    [MAX_DIM][MAX_DIM];
   logic                   flag_mem [MAX_DIM][MAX_DIM];

   logic                   is_busy;
   logic                   op_accept;
   idx_t                   i_next, j_next;
   logic                   last_elem;
   logic [RES_WIDTH-1:0]   mac_sum;
   logic                   mac_ovf;

   assign is_busy   = (state_q == ST_MAC) || (state_q == ST_WB);
   assign op_accept = bus.op_we_i && !is_busy;

   // Row-major walk over the N x M result window.
   always_comb begin
      i_next    = i_q;
      j_next    = j_q + 1'b1;
      if (j_q == m_q) begin
         j_next = '0;
         i_next = i_q + 1'b1;
      end
      last_elem = (i_q == n_q) && (j_q == m_q);
   end

   matmul_mac #(
      .DATA_WIDTH (DATA_WIDTH),
      .RES_WIDTH  (RES_WIDTH)
   ) u_mac (
      .signed_i (mode_q[MODE_SIGNED_BIT]),
      .a_i      (a_mem[i_q][kk_q]),
      .b_i      (b_mem[kk_q][j_q]),
      .acc_i    (acc_q),
      .ovf_i    (ovf_q),
      .sum_o    (mac_sum),
      .ovf_o    (mac_ovf)
   );

   // Operand store. A write in the same cycle as an accepted start lands on
   // that edge, and the first MAC read happens one cycle later.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         // NOTE: the arrays are cleared on reset because a reset must leave
         // every element reading 0; this keeps them as flops, not RAM.
         for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
               a_mem[r][c] <= '0;
               b_mem[r][c] <= '0;
            end
         end
      end else if (op_accept) begin
         if (bus.op_sel_i == OP_SEL_B) begin
            b_mem[bus.op_row_i][bus.op_col_i] <= bus.op_data_i;
         end else begin
            a_mem[bus.op_row_i][bus.op_col_i] <= bus.op_data_i;
         end
      end
   end

   // Controller: counters, accumulator, result store and status outputs.
   // NOTE: state is updated with non-blocking assignments so every read in
   // this block sees the pre-edge value, regardless of statement order.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         n_q     <= '0;
         k_q     <= '0;
         m_q     <= '0;
         i_q     <= '0;
         j_q     <= '0;
         kk_q    <= '0;
         mode_q  <= '0;
         acc_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int r = 0; r < MAX_DIM; r++) begin
            for (int c = 0; c < MAX_DIM; c++) begin
               c_mem[r][c]    <= '0;
               flag_mem[r][c] <= 1'b0;
            end
         end
      end else begin
         done_q <= 1'b0;
         err_q  <= (bus.start_i && (state_q != ST_IDLE)) ||
                   (bus.op_we_i && is_busy);

         case (state_q)
            ST_IDLE: begin
               if (bus.start_i) begin
                  n_q                     <= bus.dim_n_i;
                  k_q                     <= bus.dim_k_i;
                  m_q                     <= bus.dim_m_i;
                  mode_q[MODE_SIGNED_BIT] <= bus.signed_i;
                  mode_q[MODE_ACC_BIT]    <= bus.acc_i;
                  i_q                     <= '0;
                  j_q                     <= '0;
                  kk_q                    <= '0;
                  acc_q                   <= bus.acc_i ? c_mem[0][0] : '0;
                  ovf_q                   <= bus.acc_i & flag_mem[0][0];
                  busy_q                  <= 1'b1;
                  state_q                 <= ST_MAC;
               end
            end

            ST_MAC: begin
               acc_q <= mac_sum;
               ovf_q <= mac_ovf;
               if (kk_q == k_q) begin
                  kk_q    <= '0;
                  state_q <= ST_WB;
               end else begin
                  kk_q <= kk_q + 1'b1;
               end
            end

            ST_WB: begin
               c_mem[i_q][j_q]    <= acc_q;
               flag_mem[i_q][j_q] <= ovf_q;
               if (last_elem) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_DONE;
               end else begin
                  // The next element differs from the one being written, so
                  // its preload reads a stable pre-edge value.
                  i_q     <= i_next;
                  j_q     <= j_next;
                  acc_q   <= mode_q[MODE_ACC_BIT] ? c_mem[i_next][j_next] : '0;
                  ovf_q   <= mode_q[MODE_ACC_BIT] & flag_mem[i_next][j_next];
                  state_q <= ST_MAC;
               end
            end

            ST_DONE: state_q <= ST_IDLE;

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   // Result read port: one cycle of latency, allowed at any time.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         res_data_q <= '0;
         res_ovf_q  <= 1'b0;
      end else begin
         res_data_q <= c_mem[bus.res_row_i][bus.res_col_i];
         res_ovf_q  <= flag_mem[bus.res_row_i][bus.res_col_i];
      end
   end

   assign bus.res_data_o = res_data_q;
   assign bus.res_ovf_o  = res_ovf_q;
   assign bus.busy_o     = busy_q;
   assign bus.done_o     = done_q;
   assign bus.err_o      = err_q;

endmodule

// File: tb/tb_matmul_seq_core.sv
// -----------------------------------------------------------------------------
// tb_matmul_seq_core
// Directed bench for matmul_seq_core. Two instances share one stimulus set:
// a 32-bit-result core and a 16-bit-result core for the wrap/overflow cases;
// use16 steers strobes and reads to one of them.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_matmul_seq_core;
   import matmul_pkg::*;

   localparam int DW = 8;
   localparam int MD = 4;
   localparam int IW = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start, op_we, op_sel, signed_m, acc_m, use16;
   logic [IW-1:0] dim_n, dim_k, dim_m, op_row, op_col, res_row, res_col;
   logic [DW-1:0] op_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   matmul_seq_core_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .RES_WIDTH(32)) bus32 ();
   matmul_seq_core_if #(.DATA_WIDTH(DW), .IDX_WIDTH(IW), .RES_WIDTH(16)) bus16 ();

   assign bus32.start_i   = start & ~use16;
   assign bus32.op_we_i   = op_we & ~use16;
   assign bus32.dim_n_i   = dim_n;
   assign bus32.dim_k_i   = dim_k;
   assign bus32.dim_m_i   = dim_m;
   assign bus32.signed_i  = signed_m;
   assign bus32.acc_i     = acc_m;
   assign bus32.op_sel_i  = op_sel;
   assign bus32.op_row_i  = op_row;
   assign bus32.op_col_i  = op_col;
   assign bus32.op_data_i = op_data;
   assign bus32.res_row_i = res_row;
   assign bus32.res_col_i = res_col;

   assign bus16.start_i   = start & use16;
   assign bus16.op_we_i   = op_we & use16;
   assign bus16.dim_n_i   = dim_n;
   assign bus16.dim_k_i   = dim_k;
   assign bus16.dim_m_i   = dim_m;
   assign bus16.signed_i  = signed_m;
   assign bus16.acc_i     = acc_m;
   assign bus16.op_sel_i  = op_sel;
   assign bus16.op_row_i  = op_row;
   assign bus16.op_col_i  = op_col;
   assign bus16.op_data_i = op_data;
   assign bus16.res_row_i = res_row;
   assign bus16.res_col_i = res_col;

   matmul_seq_core #(.DATA_WIDTH(DW), .MAX_DIM(MD), .RES_WIDTH(32)) u_dut32 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus32.slave)
   );

   matmul_seq_core #(.DATA_WIDTH(DW), .MAX_DIM(MD), .RES_WIDTH(16)) u_dut16 (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus16.slave)
   );

   function automatic logic cur_busy();
      return use16 ? bus16.busy_o : bus32.busy_o;
   endfunction

   function automatic logic cur_done();
      return use16 ? bus16.done_o : bus32.done_o;
   endfunction

   function automatic logic cur_err();
      return use16 ? bus16.err_o : bus32.err_o;
   endfunction

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   task automatic write_op(input logic sel, input int r, input int c, input logic [DW-1:0] d);
      @(negedge clk);
      op_we   = 1'b1;
      op_sel  = sel;
      op_row  = IW'(r);
      op_col  = IW'(c);
      op_data = d;
      @(negedge clk);
      op_we   = 1'b0;
   endtask

   task automatic read_c(input int r, input int c, output logic [31:0] data, output logic ovf);
      @(negedge clk);
      res_row = IW'(r);
      res_col = IW'(c);
      @(negedge clk);
      data = use16 ? {16'h0, bus16.res_data_o} : bus32.res_data_o;
      ovf  = use16 ? bus16.res_ovf_o : bus32.res_ovf_o;
   endtask

   task automatic check_c(input string tag, input int r, input int c,
                          input logic [31:0] exp_data, input logic exp_ovf);
      logic [31:0] d;
      logic        o;
      read_c(r, c, d, o);
      check($sformatf("%s C%0d%0d data", tag, r, c), d, exp_data);
      check($sformatf("%s C%0d%0d ovf", tag, r, c), o, exp_ovf);
   endtask

   // Runs one job with real dimensions n,k,m. inject drives an operand write
   // and a start while busy; co_write writes A[0][0] on the start edge.
   task automatic run(input int n, input int k, input int m, input logic sgn,
                      input logic acc, input bit inject, input bit co_write,
                      input logic [DW-1:0] co_data, input string tag);
      int cyc  = 0;
      int errs = 0;
      @(negedge clk);
      dim_n    = IW'(n - 1);
      dim_k    = IW'(k - 1);
      dim_m    = IW'(m - 1);
      signed_m = sgn;
      acc_m    = acc;
      start    = 1'b1;
      if (co_write) begin
         op_we   = 1'b1;
         op_sel  = OP_SEL_A;
         op_row  = '0;
         op_col  = '0;
         op_data = co_data;
      end
      @(negedge clk);
      start = 1'b0;
      op_we = 1'b0;
      while (cur_busy() && cyc < 2000) begin
         cyc++;
         if (cur_err()) errs++;
         if (inject && cyc == 2) begin
            op_we   = 1'b1;
            op_sel  = OP_SEL_A;
            op_row  = '0;
            op_col  = '0;
            op_data = 8'd99;
         end else if (inject && cyc == 4) begin
            start = 1'b1;
         end else begin
            op_we = 1'b0;
            start = 1'b0;
         end
         @(negedge clk);
      end
      op_we = 1'b0;
      start = 1'b0;
      check({tag, " busy cycles"}, cyc, n * m * (k + 1));
      check({tag, " done after busy"}, cur_done(), 1);
      check({tag, " busy low at done"}, cur_busy(), 0);
      check({tag, " err pulses"}, errs, inject ? 2 : 0);
      @(negedge clk);
      check({tag, " done one cycle"}, cur_done(), 0);
   endtask

   initial begin
      #500us;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      int a2 [2][2];
      int b2 [2][2];
      int c2 [2][2];
      a2 = '{'{1, 2}, '{3, 4}};
      b2 = '{'{5, 6}, '{7, 8}};
      c2 = '{'{19, 22}, '{43, 50}};

      start = 0; op_we = 0; op_sel = 0; signed_m = 0; acc_m = 0; use16 = 0;
      dim_n = 0; dim_k = 0; dim_m = 0; op_row = 0; op_col = 0; op_data = 0;
      res_row = 0; res_col = 0;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst res_data", bus32.res_data_o, 0);
      check("rst res_ovf", bus32.res_ovf_o, 0);
      check("rst busy", bus32.busy_o, 0);
      check("rst done", bus32.done_o, 0);
      check("rst err", bus32.err_o, 0);
      rst = 1'b0;

      // 2x2x2 unsigned
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            write_op(OP_SEL_A, r, c, DW'(a2[r][c]));
            write_op(OP_SEL_B, r, c, DW'(b2[r][c]));
         end
      end
      run(2, 2, 2, 1'b0, 1'b0, 0, 0, 8'd0, "u222");
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            check_c("u222", r, c, c2[r][c], 1'b0);

      // Signed 4x4x4, every operand -128, then accumulate once more
      for (int r = 0; r < MD; r++) begin
         for (int c = 0; c < MD; c++) begin
            write_op(OP_SEL_A, r, c, 8'h80);
            write_op(OP_SEL_B, r, c, 8'h80);
         end
      end
      run(4, 4, 4, 1'b1, 1'b0, 0, 0, 8'd0, "s444");
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            check_c("s444", r, c, 32'd65536, 1'b0);
      run(4, 4, 4, 1'b1, 1'b1, 0, 0, 8'd0, "s444acc");
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            check_c("s444acc", r, c, 32'd131072, 1'b0);

      // N=1,K=3,M=2 on top of the full matrix: only C[0][0..1] change
      write_op(OP_SEL_A, 0, 0, 8'd1);
      write_op(OP_SEL_A, 0, 1, 8'd2);
      write_op(OP_SEL_A, 0, 2, 8'd3);
      write_op(OP_SEL_B, 0, 0, 8'd1);
      write_op(OP_SEL_B, 1, 0, 8'd1);
      write_op(OP_SEL_B, 2, 0, 8'd1);
      write_op(OP_SEL_B, 0, 1, 8'd2);
      write_op(OP_SEL_B, 1, 1, 8'd0);
      write_op(OP_SEL_B, 2, 1, 8'd1);
      run(1, 3, 2, 1'b0, 1'b0, 0, 0, 8'd0, "u132");
      for (int r = 0; r < MD; r++) begin
         for (int c = 0; c < MD; c++) begin
            if (r == 0 && c == 0)      check_c("u132", r, c, 32'd6, 1'b0);
            else if (r == 0 && c == 1) check_c("u132", r, c, 32'd5, 1'b0);
            else                       check_c("u132", r, c, 32'd131072, 1'b0);
         end
      end

      // Rejected strobes while busy; rerun proves the write never landed
      for (int r = 0; r < 2; r++) begin
         for (int c = 0; c < 2; c++) begin
            write_op(OP_SEL_A, r, c, DW'(a2[r][c]));
            write_op(OP_SEL_B, r, c, DW'(b2[r][c]));
         end
      end
      run(2, 2, 2, 1'b0, 1'b0, 1, 0, 8'd0, "busyerr");
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 2; c++)
            check_c("busyerr", r, c, c2[r][c], 1'b0);
      check_c("busyerr keep", 0, 2, 32'd131072, 1'b0);
      run(2, 2, 2, 1'b0, 1'b0, 0, 0, 8'd0, "rerun");
      check_c("rerun", 0, 0, 32'd19, 1'b0);

      // 16-bit result core: wrap and sticky overflow
      use16 = 1'b1;
      for (int kk = 0; kk < MD; kk++) begin
         write_op(OP_SEL_A, 0, kk, 8'd255);
         write_op(OP_SEL_B, kk, 0, 8'd255);
      end
      run(1, 4, 1, 1'b0, 1'b0, 0, 0, 8'd0, "w16");
      check_c("w16", 0, 0, 32'd63492, 1'b1);
      write_op(OP_SEL_A, 0, 0, 8'd1);
      write_op(OP_SEL_A, 0, 1, 8'd0);
      write_op(OP_SEL_A, 0, 2, 8'd0);
      write_op(OP_SEL_A, 0, 3, 8'd0);
      run(1, 4, 1, 1'b0, 1'b1, 0, 0, 8'd0, "w16acc");
      check_c("w16acc", 0, 0, 32'd63747, 1'b1);
      check_c("w16acc keep", 0, 1, 32'd0, 1'b0);
      // Operand write coinciding with start is used by the job
      run(1, 4, 1, 1'b0, 1'b0, 0, 1, 8'd2, "cowrite");
      check_c("cowrite", 0, 0, 32'd510, 1'b0);

      // Reset in the middle of a 4x4x4 job
      use16 = 1'b0;
      @(negedge clk);
      dim_n = 2'd3; dim_k = 2'd3; dim_m = 2'd3; signed_m = 1'b1; acc_m = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (20) @(negedge clk);
      check("midrst busy before", bus32.busy_o, 1);
      rst = 1'b1;
      #1;
      check("midrst res_data", bus32.res_data_o, 0);
      check("midrst res_ovf", bus32.res_ovf_o, 0);
      check("midrst busy", bus32.busy_o, 0);
      check("midrst done", bus32.done_o, 0);
      check("midrst err", bus32.err_o, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int r = 0; r < MD; r++)
         for (int c = 0; c < MD; c++)
            check_c("midrst", r, c, 32'd0, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/matmul_seq_core.md
# matmul_seq_core

Parametrised, sequential successor to the fixed-size matrix-multiply datapath. It holds operand matrices A (N×K) and B (K×M) and result matrix C (N×M) in internal register arrays. Dimensions are selected at run time up to MAX_DIM. A single time-shared MAC computes C = A·B or C = C + A·B, signed or unsigned, with per-element overflow flags. It sits behind the APB slave/register-file layer, which drives the load, start and read ports.

## Interface
- DATA_WIDTH, 8, operand element width
- MAX_DIM, 4, maximum matrix dimension (power of two, ≥2)
- RES_WIDTH, 32, result element width (≥ 2·DATA_WIDTH)
- IDX_WIDTH, clog2(MAX_DIM), derived localparam, index/dimension field width

- clk_i  in  1  single clock, rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  start request, sampled in IDLE only
- dim_n_i / dim_k_i / dim_m_i  in  IDX_WIDTH each  dimension minus 1 (0 → 1, MAX_DIM-1 → MAX_DIM), latched at start
- signed_i  in  1  1 = two's-complement operands and result, latched at start
- acc_i  in  1  1 = accumulate into existing C, latched at start
- op_we_i  in  1  operand write strobe
- op_sel_i  in  1  0 = A, 1 = B
- op_row_i, op_col_i  in  IDX_WIDTH each  operand element index
- op_data_i  in  DATA_WIDTH  operand element value
- res_row_i, res_col_i  in  IDX_WIDTH each  result read index
- res_data_o  out  RES_WIDTH  C[res_row][res_col], registered
- res_ovf_o  out  1  overflow flag of that element, registered
- busy_o  out  1  computation in progress
- done_o  out  1  one-cycle completion pulse
- err_o  out  1  one-cycle pulse: start or op write rejected because busy

## Operation
- FSM states: IDLE, MAC, WB, DONE.
  - IDLE → MAC on start_i. Latch dims/modes; i=j=kk=0. Load acc with C[0][0] and ovf with its flag if acc mode, else 0.
  - MAC: acc += A[i][kk]·B[kk][j], one product per cycle; kk counts 0..K-1; after kk=K-1 → WB.
  - WB: write acc to C[i][j], ovf to flag[i][j]. Advance j, then i (row-major). Preload next acc as in IDLE; → MAC, or → DONE after (N-1,M-1).
  - DONE: done_o=1 for one cycle; → IDLE.
- Arithmetic: product is 2·DATA_WIDTH bits, sign- or zero-extended per latched mode. Sum is formed at RES_WIDTH+1 bits. Stored value wraps modulo 2^RES_WIDTH. Overflow is set if the sum leaves the signed/unsigned RES_WIDTH range; it is sticky for the element, including an inherited flag in acc mode.
- C elements outside the N×M window are not modified. A/B elements outside the K range are ignored.
- op_we_i while busy: write dropped, err_o pulses. start_i while busy or in DONE: ignored, err_o pulses. Simultaneous start_i and op_we_i in IDLE: write lands, and the computation uses the new value (write takes effect on the same edge the start is accepted; first MAC read is one cycle later).
- Result reads are permitted any time. During busy they return the current stored (possibly partial) contents.
- Reset, including mid-operation: FSM → IDLE; A, B, C, flags, counters and acc cleared to 0; all outputs 0.

## Timing
- Reset values: res_data_o=0, res_ovf_o=0, busy_o=0, done_o=0, err_o=0.
- Start accepted at edge 0. busy_o is high from cycle 1 for exactly N·M·(K+1) cycles. done_o is high in the following cycle, with busy_o already low.
- Read latency is 1 cycle: index at edge t, data valid after edge t+1.
- Operand write takes effect at the strobe edge. It is readable by the MAC from the next cycle.

## Structure
- Package matmul_pkg: FSM state enum, clog2 function, mode-bit constants.
- Sub-module matmul_mac: sign/zero extension, multiply, RES_WIDTH+1 add, overflow detect, sticky flag. The core holds the arrays, counters and FSM.

## Test plan
- 2×2×2, unsigned, A=[[1,2],[3,4]], B=[[5,6],[7,8]] → C=[[19,22],[43,50]], no flags, busy 12 cycles, done 1 pulse.
- Signed 4×4×4, A all −128, B all −128 → each C element 65536, no overflow. Repeat with acc=1 → 131072.
- RES_WIDTH=16, unsigned 1×4×1, all 255 → 260100 wraps to 63492 (0xF804), res_ovf_o=1. Rerun with acc=1, small values → flag stays 1.
- N=1,K=3,M=2 with C pre-filled from an earlier 4×4 run → only C[0][0..1] change, rest preserved.
- start_i and op_we_i during busy → err_o pulses twice, operands and result unchanged vs. golden.
- rst_i asserted at mid-MAC of a 4×4×4 run → all outputs 0 immediately; a subsequent read of every C element returns 0.
